// File: rtl/noc_packet_injector_pkg.sv
// Shared NoC widths, header field layout and injector FSM encoding.
// Imported by the injector and by the header builder it shares with receivers.
package noc_packet_injector_pkg;

    localparam int NOC_DATA_WIDTH = 32;
    localparam int NOC_ID_X_WIDTH = 4;
    localparam int NOC_ID_Y_WIDTH = 4;
    localparam int NOC_LEN_WIDTH  = 8;

    // Header fields are placed by their distance from the flit MSB.
    localparam int HDR_DSTX_TOP = 1;
    localparam int HDR_DSTY_TOP = 5;
    localparam int HDR_SRCX_TOP = 9;
    localparam int HDR_SRCY_TOP = 13;
    localparam int HDR_LEN_TOP  = 17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2
    } inj_state_e;

endpackage

// File: rtl/noc_packet_injector_header_pack.sv
// Combinational NoC header builder: dst, src and length packed MSB first.
// Unused low bits are zero so receivers can compare whole header words.
module noc_header_pack
    import noc_packet_injector_pkg::*;
#(
    parameter int DATA_W = NOC_DATA_WIDTH,
    parameter int LEN_W  = NOC_LEN_WIDTH
) (
    input  logic [NOC_ID_X_WIDTH-1:0] dst_x_i,
    input  logic [NOC_ID_Y_WIDTH-1:0] dst_y_i,
    input  logic [NOC_ID_X_WIDTH-1:0] src_x_i,
    input  logic [NOC_ID_Y_WIDTH-1:0] src_y_i,
    input  logic [LEN_W-1:0]          len_i,
    output logic [DATA_W-1:0]         hdr_o
);

    // Place each field at its fixed offset below the MSB.
    always_comb begin
        hdr_o = '0;
        hdr_o[DATA_W-HDR_DSTX_TOP -: NOC_ID_X_WIDTH] = dst_x_i;
        hdr_o[DATA_W-HDR_DSTY_TOP -: NOC_ID_Y_WIDTH] = dst_y_i;
        hdr_o[DATA_W-HDR_SRCX_TOP -: NOC_ID_X_WIDTH] = src_x_i;
        hdr_o[DATA_W-HDR_SRCY_TOP -: NOC_ID_Y_WIDTH] = src_y_i;
        hdr_o[DATA_W-HDR_LEN_TOP -: LEN_W]           = len_i;
    end

endmodule

// File: rtl/noc_packet_injector.sv
// NoC traffic source: serializes one command into a header plus body flits.
// Every sender_* output is a flop; sender_ready only steers next state.
module noc_packet_injector
    import noc_packet_injector_pkg::*;
#(
    parameter logic [NOC_ID_X_WIDTH-1:0] X_ID = '0,
    parameter logic [NOC_ID_Y_WIDTH-1:0] Y_ID = '0,
    parameter int DATA_W = NOC_DATA_WIDTH,
    parameter int LEN_W  = NOC_LEN_WIDTH
) (
    input  logic                      noc_clk,
    input  logic                      noc_rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [NOC_ID_X_WIDTH-1:0] cmd_dst_x,
    input  logic [NOC_ID_Y_WIDTH-1:0] cmd_dst_y,
    input  logic [LEN_W-1:0]          cmd_len,
    input  logic [DATA_W-1:0]         cmd_seed,
    output logic                      sender_valid,
    input  logic                      sender_ready,
    output logic [DATA_W-1:0]         sender_flit,
    output logic                      sender_is_header,
    output logic                      sender_is_tail,
    output logic                      busy,
    output logic [15:0]               pkt_cnt,
    output logic [31:0]               flit_cnt
);

    inj_state_e        state_q, state_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] flit_q, flit_d;
    logic              hdr_q, hdr_d;
    logic              tail_q, tail_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0] pay_q, pay_d;
    logic [15:0]       pkt_cnt_q, pkt_cnt_d;
    logic [31:0]       flit_cnt_q, flit_cnt_d;
    logic [DATA_W-1:0] hdr_word;
    logic              xfer;

    noc_header_pack #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_hdr (
        .dst_x_i (cmd_dst_x),
        .dst_y_i (cmd_dst_y),
        .src_x_i (X_ID),
        .src_y_i (Y_ID),
        .len_i   (cmd_len),
        .hdr_o   (hdr_word)
    );

    assign xfer = valid_q && sender_ready;

    // Next state: accept a command, then advance one flit per transfer.
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        flit_d     = flit_q;
        hdr_d      = hdr_q;
        tail_d     = tail_q;
        rem_d      = rem_q;
        pay_d      = pay_q;
        pkt_cnt_d  = pkt_cnt_q;
        flit_cnt_d = flit_cnt_q;
        if (xfer) begin
            flit_cnt_d = flit_cnt_q + 32'd1;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = ST_HEAD;
                    valid_d = 1'b1;
                    flit_d  = hdr_word;
                    hdr_d   = 1'b1;
                    tail_d  = (cmd_len == '0);
                    rem_d   = cmd_len;
                    pay_d   = cmd_seed;
                end
            end
            ST_HEAD, ST_BODY: begin
                if (xfer) begin
                    hdr_d = 1'b0;
                    if (tail_q) begin
                        state_d   = ST_IDLE;
                        valid_d   = 1'b0;
                        flit_d    = '0;
                        tail_d    = 1'b0;
                        pkt_cnt_d = pkt_cnt_q + 16'd1;
                    end else begin
                        state_d = ST_BODY;
                        flit_d  = pay_q;
                        pay_d   = pay_q + DATA_W'(1);
                        tail_d  = (rem_q == LEN_W'(1));
                        rem_d   = rem_q - LEN_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any packet in flight.
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            state_q    <= ST_IDLE;
            valid_q    <= 1'b0;
            flit_q     <= '0;
            hdr_q      <= 1'b0;
            tail_q     <= 1'b0;
            rem_q      <= '0;
            pay_q      <= '0;
            pkt_cnt_q  <= '0;
            flit_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            flit_q     <= flit_d;
            hdr_q      <= hdr_d;
            tail_q     <= tail_d;
            rem_q      <= rem_d;
            pay_q      <= pay_d;
            pkt_cnt_q  <= pkt_cnt_d;
            flit_cnt_q <= flit_cnt_d;
        end
    end

    assign cmd_ready        = (state_q == ST_IDLE);
    assign busy             = (state_q != ST_IDLE);
    assign sender_valid     = valid_q;
    assign sender_flit      = flit_q;
    assign sender_is_header = hdr_q;
    assign sender_is_tail   = tail_q;
    assign pkt_cnt          = pkt_cnt_q;
    assign flit_cnt         = flit_cnt_q;

endmodule

// File: tb/tb_noc_packet_injector.sv
// Directed bench for noc_packet_injector with a transfer monitor.
// Expected flits and counters are hand-computed constants.
module tb_noc_packet_injector;

    logic        noc_clk = 1'b0;
    logic        noc_rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_dst_x = '0;
    logic [3:0]  cmd_dst_y = '0;
    logic [7:0]  cmd_len = '0;
    logic [31:0] cmd_seed = '0;
    logic        sender_valid;
    logic        sender_ready = 1'b1;
    logic [31:0] sender_flit;
    logic        sender_is_header;
    logic        sender_is_tail;
    logic        busy;
    logic [15:0] pkt_cnt;
    logic [31:0] flit_cnt;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int rdy_mode = 0;

    logic [31:0] mq_flit[$];
    bit          mq_hdr[$];
    bit          mq_tail[$];
    int          mq_cyc[$];
    int          acc_cyc[$];

    noc_packet_injector dut (
        .noc_clk          (noc_clk),
        .noc_rst          (noc_rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_dst_x        (cmd_dst_x),
        .cmd_dst_y        (cmd_dst_y),
        .cmd_len          (cmd_len),
        .cmd_seed         (cmd_seed),
        .sender_valid     (sender_valid),
        .sender_ready     (sender_ready),
        .sender_flit      (sender_flit),
        .sender_is_header (sender_is_header),
        .sender_is_tail   (sender_is_tail),
        .busy             (busy),
        .pkt_cnt          (pkt_cnt),
        .flit_cnt         (flit_cnt)
    );

    always #5 noc_clk = ~noc_clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Ready driver: always high, or a 1,0,0 repeating stall pattern.
    initial forever begin
        @(posedge noc_clk);
        cyc++;
        #1;
        if (rdy_mode == 0) sender_ready = 1'b1;
        else sender_ready = (cyc % 3 == 0);
    end

    // Monitor: logs transfers/accepts, checks stall stability.
    initial begin
        bit          pstall;
        bit          ptail;
        logic [31:0] pf;
        logic [1:0]  pht;
        pstall = 0;
        ptail  = 0;
        pf     = '0;
        pht    = '0;
        forever begin
            @(negedge noc_clk);
            if (noc_rst) begin
                pstall = 0;
                ptail  = 0;
            end else begin
                if (ptail) begin
                    check("rdy_after_tail", 32'(cmd_ready), 1);
                    check("v_after_tail", 32'(sender_valid), 0);
                end
                if (pstall) begin
                    check("stbl_v", 32'(sender_valid), 1);
                    check("stbl_flit", sender_flit, pf);
                    check("stbl_ht",
                          {30'd0, sender_is_header, sender_is_tail},
                          {30'd0, pht});
                end
                if (cmd_valid && cmd_ready) acc_cyc.push_back(cyc);
                if (sender_valid && sender_ready) begin
                    mq_flit.push_back(sender_flit);
                    mq_hdr.push_back(sender_is_header);
                    mq_tail.push_back(sender_is_tail);
                    mq_cyc.push_back(cyc);
                end
                ptail  = sender_valid && sender_ready
                         && sender_is_tail;
                pstall = sender_valid && !sender_ready;
                pf     = sender_flit;
                pht    = {sender_is_header, sender_is_tail};
            end
        end
    end

    task automatic issue(input logic [3:0] dx, input logic [3:0] dy,
                         input logic [7:0] len, input logic [31:0] seed);
        int n;
        @(posedge noc_clk);
        #1;
        cmd_dst_x = dx;
        cmd_dst_y = dy;
        cmd_len   = len;
        cmd_seed  = seed;
        cmd_valid = 1'b1;
        n = 0;
        do begin
            @(negedge noc_clk);
            n++;
        end while (!cmd_ready && n < 200);
        if (!cmd_ready) check("accept_timeout", 0, 1);
        @(posedge noc_clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge noc_clk);
        check("hdr_latency_v", 32'(sender_valid), 1);
        check("hdr_latency_h", 32'(sender_is_header), 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 500) begin
            @(negedge noc_clk);
            n++;
        end
        if (busy) check("idle_timeout", 0, 1);
    endtask

    task automatic check_pkt(input string tag, input int base,
                             input logic [31:0] exp[]);
        check({tag, "_n"}, 32'(mq_flit.size() - base), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (base + i < mq_flit.size()) begin
                check({tag, "_flit"}, mq_flit[base+i], exp[i]);
                check({tag, "_hdr"}, 32'(mq_hdr[base+i]), 32'(i == 0));
                check({tag, "_tail"}, 32'(mq_tail[base+i]),
                      32'(i == exp.size() - 1));
            end
        end
    endtask

    initial begin
        int base;
        int ab;
        int ep;
        int ef;
        logic [31:0] e1[];
        logic [31:0] e2[];
        logic [31:0] e4[];
        logic [31:0] e5[];
        int n;

        ep = 0;
        ef = 0;
        repeat (3) @(posedge noc_clk);
        #1;
        noc_rst = 1'b0;
        @(negedge noc_clk);
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        check("rst_valid", 32'(sender_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_pkt", 32'(pkt_cnt), 0);
        check("rst_flit", flit_cnt, 0);
        check("rst_ht", {30'd0, sender_is_header, sender_is_tail}, 0);

        // Header-only packet
        base = mq_flit.size();
        issue(4'd3, 4'd2, 8'd0, 32'h1234_5678);
        wait_idle();
        e1 = '{32'h3200_0000};
        check_pkt("t1", base, e1);
        ep += 1; ef += 1;
        check("t1_pkt", 32'(pkt_cnt), 32'(ep));
        check("t1_fcnt", flit_cnt, 32'(ef));

        // Three body flits, ready always high
        base = mq_flit.size();
        issue(4'd1, 4'd1, 8'd3, 32'h10);
        wait_idle();
        e4 = '{32'h1100_0300, 32'h10, 32'h11, 32'h12};
        check_pkt("t2", base, e4);
        if (mq_cyc.size() >= base + 4)
            check("t2_b2b", 32'(mq_cyc[base+3] - mq_cyc[base]), 3);
        ep += 1; ef += 4;
        check("t2_pkt", 32'(pkt_cnt), 32'(ep));
        check("t2_fcnt", flit_cnt, 32'(ef));

        // Same packet under backpressure
        rdy_mode = 1;
        base = mq_flit.size();
        issue(4'd1, 4'd1, 8'd3, 32'h10);
        wait_idle();
        check_pkt("t3", base, e4);
        if (mq_cyc.size() >= base + 4)
            check("t3_stalled", 32'(mq_cyc[base+3] - mq_cyc[base] > 3), 1);
        ep += 1; ef += 4;
        check("t3_pkt", 32'(pkt_cnt), 32'(ep));
        check("t3_fcnt", flit_cnt, 32'(ef));
        rdy_mode = 0;

        // Payload wraps past 2^32
        base = mq_flit.size();
        issue(4'hF, 4'hE, 8'd3, 32'hFFFF_FFFE);
        wait_idle();
        e4 = '{32'hFE00_0300, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0};
        check_pkt("t4", base, e4);
        ep += 1; ef += 4;
        check("t4_pkt", 32'(pkt_cnt), 32'(ep));

        // Two back-to-back commands, cmd_valid held high
        base = mq_flit.size();
        ab = acc_cyc.size();
        @(posedge noc_clk);
        #1;
        cmd_dst_x = 4'd2; cmd_dst_y = 4'd3;
        cmd_len = 8'd2; cmd_seed = 32'h100;
        cmd_valid = 1'b1;
        @(negedge noc_clk);
        @(posedge noc_clk);
        #1;
        cmd_dst_x = 4'd4; cmd_dst_y = 4'd5;
        cmd_len = 8'd1; cmd_seed = 32'hABC;
        n = 0;
        do begin
            @(negedge noc_clk);
            n++;
        end while (!cmd_ready && n < 200);
        @(posedge noc_clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge noc_clk);
        wait_idle();
        e5 = '{32'h2300_0200, 32'h100, 32'h101,
               32'h4500_0100, 32'hABC};
        check("t5_n", 32'(mq_flit.size() - base), 5);
        for (int i = 0; i < 5; i++)
            if (base + i < mq_flit.size())
                check("t5_flit", mq_flit[base+i], e5[i]);
        check("t5_acc_n", 32'(acc_cyc.size() - ab), 2);
        if (acc_cyc.size() >= ab + 2 && mq_cyc.size() >= base + 4) begin
            check("t5_gap", 32'(acc_cyc[ab+1] - mq_cyc[base+2]), 1);
            check("t5_hdr_lat", 32'(mq_cyc[base+3] - acc_cyc[ab+1]), 1);
        end
        if (mq_tail.size() >= base + 5) begin
            check("t5_tailA", 32'(mq_tail[base+2]), 1);
            check("t5_hdrB", 32'(mq_hdr[base+3]), 1);
        end
        ep += 2; ef += 5;
        check("t5_pkt", 32'(pkt_cnt), 32'(ep));
        check("t5_fcnt", flit_cnt, 32'(ef));

        // Reset while body flit 2 is on the link
        base = mq_flit.size();
        issue(4'd7, 4'd7, 8'd5, 32'h20);
        n = 0;
        while (!(sender_valid && sender_flit == 32'h21
                 && !sender_is_header) && n < 50) begin
            @(negedge noc_clk);
            n++;
        end
        if (n >= 50) check("t6_body1_timeout", 0, 1);
        @(posedge noc_clk);
        #1;
        noc_rst = 1'b1;
        @(negedge noc_clk);
        check("t6_pre_flit", sender_flit, 32'h22);
        @(negedge noc_clk);
        check("t6_valid", 32'(sender_valid), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_cmd_ready", 32'(cmd_ready), 1);
        check("t6_pkt", 32'(pkt_cnt), 0);
        check("t6_fcnt", flit_cnt, 0);
        @(posedge noc_clk);
        #1;
        noc_rst = 1'b0;
        repeat (3) @(negedge noc_clk);
        check("t6_idle_valid", 32'(sender_valid), 0);
        e2 = '{32'h7700_0500, 32'h20};
        check("t6_n", 32'(mq_flit.size() - base), 3);
        for (int i = 0; i < 2; i++)
            if (base + i < mq_flit.size())
                check("t6_flit", mq_flit[base+i], e2[i]);
        for (int i = base; i < mq_tail.size(); i++)
            check("t6_no_tail", 32'(mq_tail[i]), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected done");
        $fatal(1, "timeout");
    end

endmodule
